// File: rtl/pc_pkg.sv
// Shared constants for the fetch controller: branch condition codes, flag bit
// positions, BTB counter thresholds and the fetch FSM state type.
package pc_pkg;

    localparam int unsigned CCC_W   = 3;
    localparam int unsigned FLAGS_W = 3;
    localparam int unsigned IMM_W   = 9;
    localparam int unsigned CNT_W   = 2;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 2;

    localparam logic [CCC_W-1:0] CCC_NE = 3'b000;
    localparam logic [CCC_W-1:0] CCC_EQ = 3'b001;
    localparam logic [CCC_W-1:0] CCC_GT = 3'b010;
    localparam logic [CCC_W-1:0] CCC_LT = 3'b011;
    localparam logic [CCC_W-1:0] CCC_GE = 3'b100;
    localparam logic [CCC_W-1:0] CCC_LE = 3'b101;
    localparam logic [CCC_W-1:0] CCC_VS = 3'b110;
    localparam logic [CCC_W-1:0] CCC_AL = 3'b111;

    localparam logic [CNT_W-1:0] CNT_MIN        = 2'd0;
    localparam logic [CNT_W-1:0] CNT_MAX        = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ALLOC      = 2'd2;
    localparam logic [CNT_W-1:0] CNT_PRED_TAKEN = 2'd2;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    // Branch condition evaluation against {V,N,Z}.
    function automatic logic cond_met(input logic [CCC_W-1:0] ccc,
                                      input logic [FLAGS_W-1:0] flags);
        logic z;
        logic n;
        logic v;
        logic res;
        z   = flags[FLAG_Z];
        n   = flags[FLAG_N];
        v   = flags[FLAG_V];
        res = 1'b1;
        case (ccc)
            CCC_NE:  res = ~z;
            CCC_EQ:  res = z;
            CCC_GT:  res = ~z & ~n;
            CCC_LT:  res = n;
            CCC_GE:  res = z | ~n;
            CCC_LE:  res = n | z;
            CCC_VS:  res = v;
            default: res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup of the fetch PC,
// registered update/invalidate from the resolved EX-stage branch.
module pc_btb
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned ENTRIES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:1] lkp_pc_i,
    output logic              lkp_taken_c,
    output logic [ADDR_W-1:0] lkp_target_c,
    input  logic              upd_en_i,
    input  logic              inv_en_i,
    input  logic [ADDR_W-1:1] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 1;

    logic [ENTRIES-1:0]             valid_q,  valid_d;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag_q,    tag_d;
    logic [ENTRIES-1:0][ADDR_W-1:0] target_q, target_d;
    logic [ENTRIES-1:0][CNT_W-1:0]  cnt_q,    cnt_d;

    logic [IDX_W-1:0] lkp_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] lkp_tag;
    logic [TAG_W-1:0] upd_tag;
    logic             lkp_hit;
    logic             upd_hit;

    assign lkp_idx = lkp_pc_i[IDX_W:1];
    assign lkp_tag = lkp_pc_i[ADDR_W-1:IDX_W+1];
    assign upd_idx = upd_pc_i[IDX_W:1];
    assign upd_tag = upd_pc_i[ADDR_W-1:IDX_W+1];

    // Lookup reads the registered array, so a same-cycle update is not visible.
    assign lkp_hit      = valid_q[lkp_idx] & (tag_q[lkp_idx] == lkp_tag);
    assign lkp_taken_c  = lkp_hit & (cnt_q[lkp_idx] >= CNT_PRED_TAKEN);
    assign lkp_target_c = lkp_taken_c ? target_q[lkp_idx] : '0;

    assign upd_hit = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (upd_en_i) begin
            if (upd_taken_i) begin
                if (upd_hit) begin
                    cnt_d[upd_idx]    = (cnt_q[upd_idx] == CNT_MAX) ? CNT_MAX
                                                                    : cnt_q[upd_idx] + CNT_W'(1);
                    target_d[upd_idx] = upd_target_i;
                end else begin
                    valid_d[upd_idx]  = 1'b1;
                    tag_d[upd_idx]    = upd_tag;
                    target_d[upd_idx] = upd_target_i;
                    cnt_d[upd_idx]    = CNT_ALLOC;
                end
            end else if (upd_hit) begin
                cnt_d[upd_idx] = (cnt_q[upd_idx] == CNT_MIN) ? CNT_MIN
                                                             : cnt_q[upd_idx] - CNT_W'(1);
            end
        end else if (inv_en_i && upd_hit) begin
            valid_d[upd_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            tag_q    <= '0;
            target_q <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC controller: resolves EX-stage branches, redirects on mispredict,
// and steers the fetch PC through the BTB, stall and HLT hold paths.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int unsigned      ADDR_W      = 16,
    parameter int unsigned      BTB_ENTRIES = 8,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(16'h0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              halt_in,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_pred_taken,
    output logic [ADDR_W-1:0] fetch_pred_target,
    output logic              halted,
    input  logic              ex_valid,
    input  logic              ex_branch,
    input  logic              ex_branch_reg,
    input  logic [2:0]        ex_cond,
    input  logic [2:0]        ex_flags,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic [8:0]        ex_imm,
    input  logic [ADDR_W-1:0] ex_reg_target,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    output logic              flush,
    output logic              ex_taken
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    logic              ex_is_br;
    logic              cond;
    logic              halt_capture;
    logic              alias_inv;
    logic [ADDR_W-1:0] imm_ext;
    logic [ADDR_W-1:0] b_target;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] ex_seq_pc;
    logic [ADDR_W-1:0] redirect_pc;
    logic              btb_taken;
    logic [ADDR_W-1:0] btb_target;

    // Branch resolution; B wins over BR when both flags are set.
    assign ex_is_br    = ex_branch | ex_branch_reg;
    assign cond        = cond_met(ex_cond, ex_flags);
    assign ex_taken    = ex_valid & ex_is_br & cond;
    assign imm_ext     = {{(ADDR_W-IMM_W){ex_imm[IMM_W-1]}}, ex_imm};
    assign b_target    = ex_pc + ADDR_W'(2) + {imm_ext[ADDR_W-2:0], 1'b0};
    assign br_target   = ex_branch ? b_target : ex_reg_target;
    assign ex_seq_pc   = ex_pc + ADDR_W'(2);
    assign redirect_pc = ex_taken ? br_target : ex_seq_pc;

    assign flush = ex_valid & ((ex_taken != ex_pred_taken) |
                               (ex_taken & ex_pred_taken & (br_target != ex_pred_target)));

    // A non-branch that was predicted taken aliased onto a BTB entry.
    assign alias_inv    = ex_valid & ~ex_is_br & ex_pred_taken;
    assign halt_capture = (state_q == ST_RUN) & halt_in & ~stall & ~flush;

    pc_btb #(
        .ADDR_W  (ADDR_W),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk          (clk),
        .rst_n        (rst),
        .lkp_pc_i     (pc_q[ADDR_W-1:1]),
        .lkp_taken_c  (btb_taken),
        .lkp_target_c (btb_target),
        .upd_en_i     (ex_valid & ex_is_br),
        .inv_en_i     (alias_inv),
        .upd_pc_i     (ex_pc[ADDR_W-1:1]),
        .upd_taken_i  (ex_taken),
        .upd_target_i (br_target)
    );

    // Next-PC priority: redirect, halt hold, stall hold, prediction, sequential.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q + ADDR_W'(2);
        if (flush) begin
            pc_d = redirect_pc;
        end else if ((state_q == ST_HALTED) || halt_capture || stall) begin
            pc_d = pc_q;
        end else if (btb_taken) begin
            pc_d = btb_target;
        end
        case (state_q)
            ST_RUN:    if (halt_capture) state_d = ST_HALTED;
            ST_HALTED: if (flush)        state_d = ST_RUN;
            default:                     state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign fetch_pc          = pc_q;
    assign fetch_pred_taken  = btb_taken;
    assign fetch_pred_target = btb_target;
    assign halted            = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios followed by random traffic,
// all checked against an arithmetic reference model of fetch PC and BTB.
module tb_pc_fetch_ctrl;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned ENTRIES = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        halt_in;
    logic [15:0] fetch_pc;
    logic        fetch_pred_taken;
    logic [15:0] fetch_pred_target;
    logic        halted;
    logic        ex_valid;
    logic        ex_branch;
    logic        ex_branch_reg;
    logic [2:0]  ex_cond;
    logic [2:0]  ex_flags;
    logic [15:0] ex_pc;
    logic [8:0]  ex_imm;
    logic [15:0] ex_reg_target;
    logic        ex_pred_taken;
    logic [15:0] ex_pred_target;
    logic        flush;
    logic        ex_taken;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(
        .ADDR_W      (ADDR_W),
        .BTB_ENTRIES (ENTRIES),
        .RESET_PC    (16'h0000)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .halt_in           (halt_in),
        .fetch_pc          (fetch_pc),
        .fetch_pred_taken  (fetch_pred_taken),
        .fetch_pred_target (fetch_pred_target),
        .halted            (halted),
        .ex_valid          (ex_valid),
        .ex_branch         (ex_branch),
        .ex_branch_reg     (ex_branch_reg),
        .ex_cond           (ex_cond),
        .ex_flags          (ex_flags),
        .ex_pc             (ex_pc),
        .ex_imm            (ex_imm),
        .ex_reg_target     (ex_reg_target),
        .ex_pred_taken     (ex_pred_taken),
        .ex_pred_target    (ex_pred_target),
        .flush             (flush),
        .ex_taken          (ex_taken)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_pc;
    bit m_halted;
    bit m_v   [ENTRIES];
    int m_tag [ENTRIES];
    int m_tgt [ENTRIES];
    int m_cnt [ENTRIES];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_pc     = 0;
        m_halted = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            m_v[i]   = 1'b0;
            m_tag[i] = 0;
            m_tgt[i] = 0;
            m_cnt[i] = 0;
        end
    endfunction

    function automatic bit m_cond(input logic [2:0] ccc, input logic [2:0] f);
        bit z = f[0];
        bit n = f[1];
        bit v = f[2];
        case (ccc)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic clear_ex();
        ex_valid       = 1'b0;
        ex_branch      = 1'b0;
        ex_branch_reg  = 1'b0;
        ex_cond        = 3'd0;
        ex_flags       = 3'd0;
        ex_pc          = 16'h0;
        ex_imm         = 9'h0;
        ex_reg_target  = 16'h0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = 16'h0;
    endtask

    task automatic set_br(input logic [15:0] pc, input logic [15:0] tgt);
        clear_ex();
        ex_valid      = 1'b1;
        ex_branch_reg = 1'b1;
        ex_cond       = 3'd7;
        ex_pc         = pc;
        ex_reg_target = tgt;
    endtask

    // One clock: check all outputs against the model, then advance the model.
    task automatic step(input string tag);
        int  idx, tg, ptg, imm, tgt, nxt, eidx, etag;
        bit  hit, pt, isbr, tk, fl, ehit, nhalt;
        #1;
        idx  = (m_pc / 2) % ENTRIES;
        tg   = m_pc / (2 * ENTRIES);
        hit  = m_v[idx] && (m_tag[idx] == tg);
        pt   = hit && (m_cnt[idx] >= 2);
        ptg  = pt ? m_tgt[idx] : 0;
        isbr = ex_branch || ex_branch_reg;
        tk   = ex_valid && isbr && m_cond(ex_cond, ex_flags);
        imm  = int'(ex_imm);
        if (imm >= 256) imm -= 512;
        tgt  = ex_branch ? ((int'(ex_pc) + 2 + 2 * imm) & 'hFFFF) : int'(ex_reg_target);
        fl   = ex_valid && ((tk != ex_pred_taken) ||
                            (tk && ex_pred_taken && (tgt != int'(ex_pred_target))));

        chk({tag, ".fetch_pc"},    fetch_pc,          16'(m_pc));
        chk({tag, ".halted"},      16'(halted),       16'(m_halted));
        chk({tag, ".pred_taken"},  16'(fetch_pred_taken), 16'(pt));
        chk({tag, ".pred_target"}, fetch_pred_target, 16'(ptg));
        chk({tag, ".ex_taken"},    16'(ex_taken),     16'(tk));
        chk({tag, ".flush"},       16'(flush),        16'(fl));

        if (fl)                               nxt = tk ? tgt : ((int'(ex_pc) + 2) & 'hFFFF);
        else if (m_halted || halt_in || stall) nxt = m_pc;
        else if (pt)                          nxt = ptg;
        else                                  nxt = (m_pc + 2) & 'hFFFF;
        nhalt = m_halted ? !fl : (halt_in && !stall && !fl);

        eidx = (int'(ex_pc) / 2) % ENTRIES;
        etag = int'(ex_pc) / (2 * ENTRIES);
        ehit = m_v[eidx] && (m_tag[eidx] == etag);

        @(posedge clk);
        m_pc     = nxt;
        m_halted = nhalt;
        if (ex_valid && isbr) begin
            if (tk) begin
                if (ehit) begin
                    m_cnt[eidx] = (m_cnt[eidx] < 3) ? m_cnt[eidx] + 1 : 3;
                    m_tgt[eidx] = tgt;
                end else begin
                    m_v[eidx]   = 1'b1;
                    m_tag[eidx] = etag;
                    m_tgt[eidx] = tgt;
                    m_cnt[eidx] = 2;
                end
            end else if (ehit) begin
                m_cnt[eidx] = (m_cnt[eidx] > 0) ? m_cnt[eidx] - 1 : 0;
            end
        end else if (ex_valid && ex_pred_taken && ehit) begin
            m_v[eidx] = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b0;
        stall   = 1'b0;
        halt_in = 1'b0;
        clear_ex();
        model_reset();

        // Reset state, and EX-driven outputs live during reset.
        #12;
        chk("rst.fetch_pc",    fetch_pc,          16'h0000);
        chk("rst.pred_taken",  16'(fetch_pred_taken), 16'h0);
        chk("rst.pred_target", fetch_pred_target, 16'h0000);
        chk("rst.halted",      16'(halted),       16'h0);
        set_br(16'h0100, 16'h0040);
        #1;
        chk("rst.ex_taken", 16'(ex_taken), 16'h1);
        chk("rst.flush",    16'(flush),    16'h1);
        clear_ex();
        @(negedge clk);
        rst = 1'b1;

        // Sequential fetch out of reset.
        repeat (3) step("seq");
        chk("seq.pc6", fetch_pc, 16'h0006);
        repeat (5) step("seq");
        chk("seq.pc10", fetch_pc, 16'h0010);

        // Taken B, not predicted: allocate and redirect.
        clear_ex();
        ex_valid = 1'b1; ex_branch = 1'b1; ex_pc = 16'h0010; ex_imm = 9'd3;
        ex_cond = 3'b001; ex_flags = 3'b001;
        #1 chk("b.flush", 16'(flush), 16'h1);
        step("b_alloc");
        clear_ex();
        chk("b.redirect", fetch_pc, 16'h0018);

        // Refetch 0010: predicted taken, then resolved not taken.
        set_br(16'h0102, 16'h0010);
        step("to10");
        clear_ex();
        chk("hit.pred_taken",  16'(fetch_pred_taken), 16'h1);
        chk("hit.pred_target", fetch_pred_target, 16'h0018);
        ex_valid = 1'b1; ex_branch = 1'b1; ex_pc = 16'h0010; ex_imm = 9'd3;
        ex_cond = 3'b000; ex_flags = 3'b001;
        ex_pred_taken = 1'b1; ex_pred_target = 16'h0018;
        #1 chk("nt.flush", 16'(flush), 16'h1);
        step("nt");
        clear_ex();
        chk("nt.redirect", fetch_pc, 16'h0012);
        set_br(16'h0102, 16'h0010);
        step("to10b");
        clear_ex();
        chk("cnt1.pred_taken", 16'(fetch_pred_taken), 16'h0);

        // HLT capture and release by an older mispredicted BR.
        set_br(16'h0104, 16'h0020);
        step("to20");
        clear_ex();
        halt_in = 1'b1;
        step("hlt");
        halt_in = 1'b0;
        chk("hlt.halted", 16'(halted), 16'h1);
        repeat (5) step("hold");
        chk("hold.pc", fetch_pc, 16'h0020);
        set_br(16'h001C, 16'h0040);
        step("release");
        clear_ex();
        chk("release.pc",     fetch_pc,     16'h0040);
        chk("release.halted", 16'(halted), 16'h0);

        // Stall hold, then stall with a simultaneous redirect.
        set_br(16'h0106, 16'h0030);
        step("to30");
        clear_ex();
        stall = 1'b1;
        repeat (3) step("stall");
        chk("stall.pc", fetch_pc, 16'h0030);
        set_br(16'h0108, 16'h0050);
        step("stall_flush");
        clear_ex();
        stall = 1'b0;
        chk("stall_flush.pc", fetch_pc, 16'h0050);

        // Negative offset to 0000 and fetch wrap at FFFE.
        ex_valid = 1'b1; ex_branch = 1'b1; ex_pc = 16'h0000; ex_imm = 9'h1FF;
        ex_cond = 3'b111;
        step("neg");
        clear_ex();
        chk("neg.pc", fetch_pc, 16'h0000);
        set_br(16'h010A, 16'hFFFE);
        step("toFFFE");
        clear_ex();
        chk("wrap.pre", fetch_pc, 16'hFFFE);
        step("wrap");
        chk("wrap.pc", fetch_pc, 16'h0000);

        // Random traffic confined to a small address window to exercise BTB hits.
        repeat (600) begin
            stall          = ($urandom_range(0, 99) < 20);
            halt_in        = ($urandom_range(0, 99) < 8);
            ex_valid       = ($urandom_range(0, 99) < 75);
            ex_branch      = 1'($urandom_range(0, 1));
            ex_branch_reg  = ($urandom_range(0, 3) == 0);
            ex_cond        = 3'($urandom);
            ex_flags       = 3'($urandom);
            ex_pc          = ($urandom_range(0, 1) == 1) ? 16'(m_pc)
                                                         : 16'($urandom_range(0, 31) * 2);
            ex_imm         = 9'($urandom);
            ex_reg_target  = 16'($urandom_range(0, 31) * 2);
            ex_pred_taken  = 1'($urandom_range(0, 1));
            ex_pred_target = ex_pred_taken ? 16'($urandom_range(0, 31) * 2) : 16'h0;
            step("rnd");
        end

        // Reset mid-operation with a live EX branch.
        stall   = 1'b0;
        halt_in = 1'b0;
        set_br(16'h0004, 16'h0020);
        rst = 1'b0;
        #1;
        chk("midrst.fetch_pc",    fetch_pc,          16'h0000);
        chk("midrst.pred_taken",  16'(fetch_pred_taken), 16'h0);
        chk("midrst.pred_target", fetch_pred_target, 16'h0000);
        chk("midrst.halted",      16'(halted),       16'h0);
        model_reset();
        @(negedge clk);
        clear_ex();
        rst = 1'b1;
        repeat (20) step("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
  ADDR_W, 16, PC width in bits
  BTB_ENTRIES, 8, branch target buffer entries; power of two, 2 to 64
  RESET_PC, 16'h0000, fetch address after reset
REQ-002 SHALL have ports, one per line:
  clk  in  1  single clock, rising edge
  rst  in  1  reset, asynchronous, active-low
  stall  in  1  hazard hold of fetch PC
  halt_in  in  1  instruction at fetch_pc decodes as HLT
  fetch_pc  out  ADDR_W  instruction memory address
  fetch_pred_taken  out  1  BTB prediction for fetch_pc
  fetch_pred_target  out  ADDR_W  predicted target; 0 when not taken
  halted  out  1  block is in HALTED
  ex_valid  in  1  EX-stage instruction valid
  ex_branch  in  1  EX instruction is B (PC-relative)
  ex_branch_reg  in  1  EX instruction is BR (register target)
  ex_cond  in  3  condition field ccc
  ex_flags  in  3  {V,N,Z}
  ex_pc  in  ADDR_W  address of EX instruction
  ex_imm  in  9  signed branch offset in instructions
  ex_reg_target  in  ADDR_W  rs data for BR
  ex_pred_taken  in  1  prediction carried with EX instruction
  ex_pred_target  in  ADDR_W  predicted target carried with it
  flush  out  1  redirect; kills IF/ID, combinational from EX inputs
  ex_taken  out  1  resolved direction

Function
REQ-003 SHALL evaluate ccc: 000 ~Z; 001 Z; 010 ~Z&~N; 011 N; 100 Z|~N; 101 N|Z; 110 V; 111 always.
REQ-004 SHALL set ex_taken = ex_valid & (ex_branch|ex_branch_reg) & cond; ex_branch takes precedence if both set.
REQ-005 SHALL compute B target = ex_pc + 2 + (sign-extended ex_imm << 1), BR target = ex_reg_target, all mod 2^ADDR_W.
REQ-006 SHALL assert flush when ex_valid and (ex_taken != ex_pred_taken, or both 1 and target != ex_pred_target).
REQ-007 SHALL redirect fetch_pc on the next edge to the resolved target if taken, else ex_pc + 2.
REQ-008 SHALL select next fetch_pc by priority: redirect > HALTED or halt capture (hold) > stall (hold) > BTB predicted target > fetch_pc + 2.
REQ-009 SHALL implement states RUN and HALTED.
  RUN to HALTED: halt_in & ~stall & ~flush; fetch_pc holds at the HLT address.
  HALTED to RUN: flush only; a wrong-path HLT is cancelled.
REQ-010 SHALL look up the BTB direct-mapped.
  Index = fetch_pc[log2(BTB_ENTRIES):1]; tag = remaining upper bits.
  Entry = valid, tag, target, 2-bit saturating counter.
  Predict taken on valid & tag match & counter >= 2.
REQ-011 SHALL update the BTB when ex_valid & (ex_branch|ex_branch_reg).
  Taken, hit: counter +1 saturating at 3; target rewritten.
  Taken, miss: allocate or replace with counter 2.
  Not taken, hit: counter -1 saturating at 0.
  Not taken, miss: no change.
REQ-012 SHALL, when ex_valid with neither branch flag and ex_pred_taken=1 (alias), flush to ex_pc + 2 and invalidate the matching entry.
REQ-013 SHALL give lookup the pre-update entry contents when lookup and update hit the same index in one cycle.
REQ-014 SHALL perform BTB updates regardless of stall or HALTED.
REQ-015 SHALL wrap fetch_pc + 2 from 16'hFFFE to 16'h0000 with no error.

Reset
REQ-016 SHALL, while rst=0, force fetch_pc=RESET_PC, state RUN, halted=0, all BTB valid bits, counters and targets to 0.
REQ-017 SHALL, while rst=0, hold fetch_pred_taken=0 and fetch_pred_target=0; flush and ex_taken depend on EX inputs only.
REQ-018 SHALL leave in-flight EX state unrecorded when reset is asserted mid-operation; fetch restarts at RESET_PC.

Structure
REQ-019 SHALL place ccc encodings, flag bit indices (Z=0, N=1, V=2) and counter constants in shared package pc_pkg.
REQ-020 SHALL implement BTB storage, lookup and update in sub-module pc_btb; condition evaluation and next-PC mux stay in pc_fetch_ctrl.

Verification
REQ-021 Reset, no stall, 3 cycles -> fetch_pc 0000, 0002, 0004, 0006; pred_taken 0.
REQ-022 EX B at 0010, imm=+3, ccc=001, Z=1, pred 0 -> flush=1, next fetch_pc 0018, BTB index 0 allocated with counter 2.
REQ-023 Refetch 0010 -> pred_taken=1, target 0018. EX ccc=000, Z=1 -> flush, next fetch_pc 0012, counter 1.
REQ-024 halt_in at 0020 -> HALTED, fetch_pc holds 0020 for 5 cycles. Older EX BR mispredict to 0040 -> RUN, fetch_pc 0040.
REQ-025 stall=1 for 3 cycles at 0030 -> fetch_pc held. stall with simultaneous flush -> redirect wins.
REQ-026 imm=-1 at ex_pc 0000 -> target 0000; fetch_pc FFFE + 2 -> 0000.
